idec_pipe: RTL and testbench
============================

Name: idec_pipe

Overview:
- Parametrised successor to the two-stage instruction decoder.
- Owns the IR0/IR1 pipeline registers with valid bits, a fetch handshake, a latched condition-flag register and a memory-access FSM with a wait-cycle timeout.
- Produces register-file, mux, ALU, memory and jump controls for the datapath. Sits between instruction fetch and the register file / ALU / memory port.

Parameters:
- RAW, 4: register address width. Instruction format is ffff | d(RAW) | s(RAW) | m | ccc; IW = 4+2*RAW+4 (16 at default).
- NSEL, 2: mux select width. Addresses below 3 select directly; all others select 2'b11.
- MEM_TMO, 15: maximum MEM_WAIT cycles before abort. Counter width is clog2(MEM_TMO+1).

Ports:
- clk in 1: clock.
- reset in 1: asynchronous active-high reset.
- instr_valid in 1: fetch word present.
- instr in IW: fetch word.
- instr_ready out 1: decoder accepts word this cycle.
- flags_in in 4: {sign,carry,parity,zero} from ALU.
- mem_ack in 1: memory completes access.
- aluf out 4: ALU function, from IR1.
- readAddrA out RAW: read port A address, from IR0 d field.
- readAddrB out RAW: read port B address, from IR0 s field.
- writeAddress out RAW: write address, from IR1 d field.
- selA out NSEL: mux select for operand A.
- selB out NSEL: mux select for operand B.
- wr_en out 1: register write, valid IR1 retiring.
- gate out 1: flag register update.
- sel_addr_reg out 1: memory address from r2.
- rw out 1: 0 = memory write.
- mem_req out 1: memory access pending.
- mem_err out 1: one-cycle timeout pulse.
- dojump out 1: PC load.
- wrAddr out 1: address register write.
- flags_q out 4: latched flags.

Behaviour:
- Reset state:
  - ir0_v = ir1_v = 0, IR0 = IR1 = 0, flags_q = 0, state RUN, counter 0.
  - Every output is 0 except rw = 1 and instr_ready = 0 during reset.
- FSM states: RUN, MEM_WAIT.
- RUN:
  - instr_ready = ~hold.
  - On instr_valid & instr_ready, IR0 <= instr and ir0_v <= 1; otherwise ir0_v <= 0 if IR0 advanced (bubble).
  - IR1 <= IR0 and ir1_v <= ir0_v every non-hold cycle.
- Memory access: mem_op = ir1_v & m1 & (d1==0) (write), or ir0_v & m0 & (s0==0) (read).
  - A mem_op in RUN asserts mem_req combinationally. Without mem_ack in the same cycle, go to MEM_WAIT. hold = 1 while mem_req & ~mem_ack.
  - mem_ack in the same cycle completes the access with zero wait.
- MEM_WAIT:
  - Pipeline frozen, mem_req = 1, counter increments.
  - On mem_ack: return to RUN and clear the counter. The op retires/advances next edge.
  - When counter == MEM_TMO with no ack: pulse mem_err, invalidate the faulting instruction (ir1_v or ir0_v <= 0), return to RUN.
  - mem_ack and timeout in the same cycle: ack wins.
- Decode rules (only when the owning IR is valid; all forced 0 otherwise):
  - sel_addr_reg = memory-read or memory-write condition.
  - rw = ~(ir1_v & m1 & d1==0).
  - dojump = ir1_v & ~hold & (d1==1) & jmpchk(ccc1, flags_q).
  - jmpchk: unc=1, pos=~sign, neg=sign, zero, parodd=parity, carry, ncarry=~carry, nzero=~zero.
  - wrAddr = ir1_v & ~hold & d1==2.
  - gate = ir1_v & ~hold & |aluf.
  - wr_en = ir1_v & ~hold & d1>2.
- flags_q <= flags_in on gate.
- Squash: ir0_v <= 0 at the edge where
  - dojump = 1 (wins over a simultaneous fetch; the fetched word is also dropped), or
  - IR0 is an immediate load (s0==0 & d0!=0 & ~m0); the next fetched word is data, not decoded, and enters IR1 as a bubble, or
  - a memory write retires.
- Reset mid-MEM_WAIT: immediate return to reset state; mem_req drops asynchronously.

Optional Feature:
- IDEC_PIPE_HAZARD_EN defined: compare s0/d0 (when ≥3) against d1 with ir1_v & ir1 writing. On a match, stall IR0 one cycle (instr_ready = 0, insert IR1 bubble).
- Undefined: no interlock; software must schedule.

Decomposition:
- Package idec_pkg holds:
  - condition codes (UNC..NZERO);
  - register numbers (R_IMM=0, R_PC=1, R_ADDR=2);
  - state enum {RUN, MEM_WAIT};
  - flag bit indices.
- One sub-module: idec_jmpchk, a combinational condition evaluator.

Test Plan:
- Reset then stream 0x3450, 0x5670 with instr_valid=1 → 2 cycles later aluf=3, writeAddress=4, wr_en=1, gate=1; rw=1.
- IR1 d=1, ccc=011, flags_q zero=1 → dojump=1 for one cycle. The fetched word behind it never reaches IR1 (wr_en=0 next cycle).
- Memory write 0x1008 (d=0, m=1), mem_ack after 3 cycles → mem_req high 4 cycles, rw=0, instr_ready=0 for 3 cycles, pipeline resumes.
- mem_ack never arrives, MEM_TMO=15 → mem_err pulses at cycle 16, op squashed, state RUN.
- Assert reset during MEM_WAIT → mem_req=0 and ir1_v=0 without a clock edge.
- With IDEC_PIPE_HAZARD_EN: 0x1530 then 0x2350 → one bubble, instr_ready=0 one cycle. Without the macro: no bubble.

Source files
------------

// File: rtl/idec_pkg.sv
// idec_pkg: shared definitions for the idec_pipe instruction decoder.
//   - cc_e     : 3-bit jump condition codes carried in the ccc field
//   - R_*      : register numbers that have special decode meaning
//   - state_e  : memory-access FSM states
//   - FLAG_*   : bit positions inside the {sign,carry,parity,zero} flag word
package idec_pkg;

  typedef enum logic [2:0] {
    CC_UNC    = 3'd0,
    CC_POS    = 3'd1,
    CC_NEG    = 3'd2,
    CC_ZERO   = 3'd3,
    CC_PARODD = 3'd4,
    CC_CARRY  = 3'd5,
    CC_NCARRY = 3'd6,
    CC_NZERO  = 3'd7
  } cc_e;

  // Register numbers with side effects: 0 = immediate / memory data,
  // 1 = program counter (jump), 2 = memory address register.
  localparam int R_IMM  = 0;
  localparam int R_PC   = 1;
  localparam int R_ADDR = 2;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_PARITY = 1;
  localparam int FLAG_CARRY  = 2;
  localparam int FLAG_SIGN   = 3;

endpackage

// File: rtl/idec_pipe_jmpchk.sv
// idec_jmpchk: combinational jump-condition evaluator.
// Ports:
//   ccc   in  3 : condition code from the instruction in IR1
//   flags in  4 : latched {sign,carry,parity,zero}
//   take  out 1 : condition satisfied
module idec_jmpchk
  import idec_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [3:0] flags,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (cc_e'(ccc))
      CC_UNC:    take = 1'b1;
      CC_POS:    take = ~flags[FLAG_SIGN];
      CC_NEG:    take = flags[FLAG_SIGN];
      CC_ZERO:   take = flags[FLAG_ZERO];
      CC_PARODD: take = flags[FLAG_PARITY];
      CC_CARRY:  take = flags[FLAG_CARRY];
      CC_NCARRY: take = ~flags[FLAG_CARRY];
      CC_NZERO:  take = ~flags[FLAG_ZERO];
    endcase
  end

endmodule

// File: rtl/idec_pipe.sv
// idec_pipe: two-stage instruction decoder (IR0 decode/read, IR1 execute/retire)
// with fetch handshake, latched ALU flags and a memory-access wait FSM with
// timeout abort.
// Instruction word: ffff | d(RAW) | s(RAW) | m | ccc
// Ports:
//   clk, reset (async, active high)
//   instr_valid/instr/instr_ready : fetch handshake
//   flags_in     : ALU flags, latched into flags_q when gate=1
//   mem_ack      : memory access complete
//   aluf, writeAddress, wr_en, gate, dojump, wrAddr : IR1 (retire) controls
//   readAddrA/B, selA/selB                          : IR0 (operand) controls
//   sel_addr_reg, rw, mem_req, mem_err              : memory port controls
// Optional build macro IDEC_PIPE_HAZARD_EN: adds a read-after-write interlock
// that stalls IR0 for one cycle when it reads a register IR1 is writing.
module idec_pipe
  import idec_pkg::*;
#(
  parameter int  RAW     = 4,
  parameter int  NSEL    = 2,
  parameter int  MEM_TMO = 15,
  localparam int IW      = 4 + 2*RAW + 4,
  localparam int CW      = $clog2(MEM_TMO + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [IW-1:0]   instr,
  output logic            instr_ready,
  input  logic [3:0]      flags_in,
  input  logic            mem_ack,
  output logic [3:0]      aluf,
  output logic [RAW-1:0]  readAddrA,
  output logic [RAW-1:0]  readAddrB,
  output logic [RAW-1:0]  writeAddress,
  output logic [NSEL-1:0] selA,
  output logic [NSEL-1:0] selB,
  output logic            wr_en,
  output logic            gate,
  output logic            sel_addr_reg,
  output logic            rw,
  output logic            mem_req,
  output logic            mem_err,
  output logic            dojump,
  output logic            wrAddr,
  output logic [3:0]      flags_q
);

  // IR1 only keeps the fields it decodes; the s field is consumed in IR0.
  logic [IW-1:0]  ir0_reg;
  logic           ir0_v_reg;
  logic [3:0]     ir1_f_reg;
  logic [RAW-1:0] ir1_d_reg;
  logic           ir1_m_reg;
  logic [2:0]     ir1_c_reg;
  logic           ir1_v_reg;
  state_e         state_reg;
  logic [CW-1:0]  cnt_reg;

  logic [RAW-1:0] d0, s0;
  logic           m0;
  logic           wr_op, rd_op, mem_op;
  logic           hold, stall, fetch, timeout;
  logic           jmp_take, imm0, squash;

  assign d0 = ir0_reg[IW-5 -: RAW];
  assign s0 = ir0_reg[IW-5-RAW -: RAW];
  assign m0 = ir0_reg[3];

  // Memory write is executed from IR1, memory read is started from IR0.
  assign wr_op  = ir1_v_reg & ir1_m_reg & (ir1_d_reg == RAW'(R_IMM));
  assign rd_op  = ir0_v_reg & m0 & (s0 == RAW'(R_IMM));
  assign mem_op = wr_op | rd_op;

  assign mem_req = (state_reg == MEM_WAIT) | mem_op;
  // An ack in the same cycle releases the pipeline; the op advances at this edge.
  assign hold    = mem_req & ~mem_ack;
  assign timeout = (state_reg == MEM_WAIT) & (cnt_reg == CW'(MEM_TMO)) & ~mem_ack;

`ifdef IDEC_PIPE_HAZARD_EN
  // Registers 0..2 have side-effect semantics and are never interlocked.
  assign stall = ~hold & ir0_v_reg & ir1_v_reg & (ir1_d_reg > RAW'(R_ADDR)) &
                 (((s0 > RAW'(R_ADDR)) & (s0 == ir1_d_reg)) |
                  ((d0 > RAW'(R_ADDR)) & (d0 == ir1_d_reg)));
`else
  assign stall = 1'b0;
`endif

  assign instr_ready = ~reset & ~hold & ~stall;
  assign fetch       = instr_valid & instr_ready;

  idec_jmpchk u_jmpchk (
    .ccc   (ir1_c_reg),
    .flags (flags_q),
    .take  (jmp_take)
  );

  // IR0 operand decode
  assign readAddrA = ir0_v_reg ? d0 : '0;
  assign readAddrB = ir0_v_reg ? s0 : '0;
  assign selA = ~ir0_v_reg ? '0 : ((d0 < RAW'(3)) ? NSEL'(d0) : {NSEL{1'b1}});
  assign selB = ~ir0_v_reg ? '0 : ((s0 < RAW'(3)) ? NSEL'(s0) : {NSEL{1'b1}});

  // IR1 retire decode; side effects only when IR1 actually retires (~hold)
  assign aluf         = ir1_v_reg ? ir1_f_reg : 4'd0;
  assign writeAddress = ir1_v_reg ? ir1_d_reg : '0;
  assign wr_en        = ir1_v_reg & ~hold & (ir1_d_reg > RAW'(R_ADDR));
  assign gate         = ir1_v_reg & ~hold & (|ir1_f_reg);
  assign dojump       = ir1_v_reg & ~hold & (ir1_d_reg == RAW'(R_PC)) & jmp_take;
  assign wrAddr       = ir1_v_reg & ~hold & (ir1_d_reg == RAW'(R_ADDR));
  assign sel_addr_reg = mem_op;
  assign rw           = ~wr_op;
  assign mem_err      = timeout;

  // Immediate load: the following fetch word is the literal, not an opcode.
  assign imm0   = ir0_v_reg & (s0 == RAW'(R_IMM)) & (d0 != RAW'(R_IMM)) & ~m0;
  assign squash = dojump | imm0 | (wr_op & ~hold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir0_reg   <= '0;
      ir0_v_reg <= 1'b0;
      ir1_f_reg <= '0;
      ir1_d_reg <= '0;
      ir1_m_reg <= 1'b0;
      ir1_c_reg <= '0;
      ir1_v_reg <= 1'b0;
      flags_q   <= '0;
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      if (gate) begin
        flags_q <= flags_in;
      end

      case (state_reg)
        RUN: begin
          if (hold) begin
            state_reg <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end else if (timeout) begin
            // Abort: drop the faulting instruction, the write has priority.
            state_reg <= RUN;
            cnt_reg   <= '0;
            if (wr_op) begin
              ir1_v_reg <= 1'b0;
            end else begin
              ir0_v_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      endcase

      if (~hold) begin
        if (stall) begin
          ir1_v_reg <= 1'b0;
        end else begin
          ir1_f_reg <= ir0_reg[IW-1 -: 4];
          ir1_d_reg <= d0;
          ir1_m_reg <= m0;
          ir1_c_reg <= ir0_reg[2:0];
          ir1_v_reg <= ir0_v_reg;
          if (fetch) begin
            ir0_reg <= instr;
          end
          ir0_v_reg <= fetch & ~squash;
        end
      end
    end
  end

endmodule

// File: tb/tb_idec_pipe.sv
module tb_idec_pipe;

  localparam int RAW     = 4;
  localparam int NSEL    = 2;
  localparam int MEM_TMO = 15;
`ifdef IDEC_PIPE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [3:0]  flags_in = '0;
  logic        mem_ack = 1'b0;
  logic        instr_ready;
  logic [3:0]  aluf;
  logic [3:0]  readAddrA, readAddrB, writeAddress;
  logic [1:0]  selA, selB;
  logic        wr_en, gate, sel_addr_reg, rw, mem_req, mem_err, dojump, wrAddr;
  logic [3:0]  flags_q;

  idec_pipe #(.RAW(RAW), .NSEL(NSEL), .MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .flags_in(flags_in), .mem_ack(mem_ack),
    .aluf(aluf), .readAddrA(readAddrA), .readAddrB(readAddrB),
    .writeAddress(writeAddress), .selA(selA), .selB(selB), .wr_en(wr_en),
    .gate(gate), .sel_addr_reg(sel_addr_reg), .rw(rw), .mem_req(mem_req),
    .mem_err(mem_err), .dojump(dojump), .wrAddr(wrAddr), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] aluf;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] wa;
    logic [1:0] sela;
    logic [1:0] selb;
    logic       wr_en;
    logic       gate;
    logic       sel_addr_reg;
    logic       rw;
    logic       mem_req;
    logic       mem_err;
    logic       dojump;
    logic       wraddr;
    logic       instr_ready;
    logic [3:0] flags_q;
  } obs_t;

  obs_t expq[$];
  obs_t snap;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: instruction words, valid bits, wait/timeout count
  int m_ir0, m_ir1, m_cnt, m_flags;
  bit m_v0, m_v1, m_wait;

  function automatic obs_t dut_obs();
    obs_t o;
    o.aluf = aluf; o.ra = readAddrA; o.rb = readAddrB; o.wa = writeAddress;
    o.sela = selA; o.selb = selB; o.wr_en = wr_en; o.gate = gate;
    o.sel_addr_reg = sel_addr_reg; o.rw = rw; o.mem_req = mem_req;
    o.mem_err = mem_err; o.dojump = dojump; o.wraddr = wrAddr;
    o.instr_ready = instr_ready; o.flags_q = flags_q;
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] check %s ok (%0d)", name, act);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, push prediction,
  // snapshot DUT at negedge, advance the model over the posedge.
  task automatic cycle(input bit iv, input int iw, input int fl, input bit ack);
    obs_t e;
    int f1, d1, m1, c1, d0, s0, m0;
    bit wr_op, rd_op, req, hold, stall, take, err, sq;
    instr_valid = iv; instr = 16'(iw); flags_in = 4'(fl); mem_ack = ack;
    f1 = (m_ir1 >> 12) & 15; d1 = (m_ir1 >> 8) & 15; m1 = (m_ir1 >> 3) & 1; c1 = m_ir1 & 7;
    d0 = (m_ir0 >> 8) & 15;  s0 = (m_ir0 >> 4) & 15; m0 = (m_ir0 >> 3) & 1;
    wr_op = m_v1 && m1 == 1 && d1 == 0;
    rd_op = m_v0 && m0 == 1 && s0 == 0;
    req   = m_wait || wr_op || rd_op;
    hold  = req && !ack;
    err   = m_wait && m_cnt == MEM_TMO && !ack;
    stall = HAZ && !hold && m_v0 && m_v1 && d1 >= 3 &&
            ((s0 >= 3 && s0 == d1) || (d0 >= 3 && d0 == d1));
    case (c1)
      0: take = 1'b1;
      1: take = ((m_flags >> 3) & 1) == 0;
      2: take = ((m_flags >> 3) & 1) == 1;
      3: take = (m_flags & 1) == 1;
      4: take = ((m_flags >> 1) & 1) == 1;
      5: take = ((m_flags >> 2) & 1) == 1;
      6: take = ((m_flags >> 2) & 1) == 0;
      default: take = (m_flags & 1) == 0;
    endcase
    e.aluf = m_v1 ? 4'(f1) : 4'd0;
    e.wa   = m_v1 ? 4'(d1) : 4'd0;
    e.ra   = m_v0 ? 4'(d0) : 4'd0;
    e.rb   = m_v0 ? 4'(s0) : 4'd0;
    e.sela = !m_v0 ? 2'd0 : (d0 < 3 ? 2'(d0) : 2'd3);
    e.selb = !m_v0 ? 2'd0 : (s0 < 3 ? 2'(s0) : 2'd3);
    e.wr_en  = m_v1 && !hold && d1 > 2;
    e.gate   = m_v1 && !hold && f1 != 0;
    e.dojump = m_v1 && !hold && d1 == 1 && take;
    e.wraddr = m_v1 && !hold && d1 == 2;
    e.sel_addr_reg = wr_op || rd_op;
    e.rw      = !wr_op;
    e.mem_req = req;
    e.mem_err = err;
    e.instr_ready = !hold && !stall;
    e.flags_q = 4'(m_flags);
    expq.push_back(e);
    @(negedge clk);
    snap = dut_obs();
    @(posedge clk);
    if (e.gate) m_flags = fl;
    if (hold) begin
      if (err) begin
        m_wait = 0; m_cnt = 0;
        if (wr_op) m_v1 = 0; else m_v0 = 0;
      end else if (m_wait) m_cnt++;
      else m_wait = 1;
    end else begin
      m_wait = 0; m_cnt = 0;
      if (stall) m_v1 = 0;
      else begin
        sq = e.dojump || (m_v0 && s0 == 0 && d0 != 0 && m0 == 0) || wr_op;
        m_ir1 = m_ir0; m_v1 = m_v0;
        if (iv) m_ir0 = iw;
        m_v0 = iv && !sq;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 0; instr = '0; flags_in = '0; mem_ack = 0;
    m_ir0 = 0; m_ir1 = 0; m_v0 = 0; m_v1 = 0; m_wait = 0; m_cnt = 0; m_flags = 0;
    expq.delete();
    #1;
    check("rst_instr_ready", int'(instr_ready), 0);
    check("rst_rw", int'(rw), 1);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_aluf", int'(aluf), 0);
    check("rst_flags_q", int'(flags_q), 0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor
  obs_t mon_exp, mon_act;
  int   mon_n = 0;
  always begin
    @(negedge clk);
    if (!reset && expq.size() > 0) begin
      mon_exp = expq.pop_front();
      mon_act = dut_obs();
      mon_n++;
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL scoreboard txn %0d: got %h expected %h", mon_n, mon_act, mon_exp);
      end else begin
        $display("[TB] txn %0d ok %h", mon_n, mon_act);
      end
    end
  end

  initial begin
    int nreq, nnr, first, blackout;
    #1;
    do_reset();

    // Stream two ALU ops
    cycle(1, 'h3450, 0, 0); cycle(1, 'h5670, 0, 0); cycle(0, 0, 0, 0);
    check("stream_aluf", int'(snap.aluf), 3);
    check("stream_waddr", int'(snap.wa), 4);
    check("stream_wr_en", int'(snap.wr_en), 1);
    check("stream_gate", int'(snap.gate), 1);
    check("stream_rw", int'(snap.rw), 1);
    idle(3);

    // Conditional jump on zero, fetched word behind it dropped
    cycle(1, 'h1470, 0, 0); cycle(1, 'h0113, 0, 0); cycle(0, 0, 1, 0);
    cycle(1, 'h3670, 0, 0);
    check("jump_dojump", int'(snap.dojump), 1);
    cycle(0, 0, 0, 0);
    check("jump_pulse_end", int'(snap.dojump), 0);
    check("jump_bubble_wr_en", int'(snap.wr_en), 0);
    cycle(0, 0, 0, 0);
    check("jump_dropped_wr_en", int'(snap.wr_en), 0);
    idle(2);

    // Memory write acknowledged after 3 wait cycles
    cycle(1, 'h1008, 0, 0); cycle(0, 0, 0, 1);
    nreq = 0; nnr = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, k == 3);
      nreq += int'(snap.mem_req);
      nnr  += int'(!snap.instr_ready);
      if (k == 0) check("memwr_rw", int'(snap.rw), 0);
    end
    check("memwr_req_cycles", nreq, 4);
    check("memwr_notready_cycles", nnr, 3);
    cycle(0, 0, 0, 0);
    check("memwr_req_done", int'(snap.mem_req), 0);
    idle(2);

    // Memory write never acknowledged: timeout
    cycle(1, 'h1008, 0, 0); cycle(0, 0, 0, 1);
    first = -1;
    for (int k = 0; k < 40; k++) begin
      cycle(0, 0, 0, 0);
      if (snap.mem_err) begin first = k; break; end
    end
    check("timeout_cycle", first, 16);
    cycle(0, 0, 0, 0);
    check("timeout_req_dropped", int'(snap.mem_req), 0);
    check("timeout_ready", int'(snap.instr_ready), 1);
    idle(2);

    // Read-after-write pair: bubble only with the interlock
    nnr = 0;
    cycle(1, 'h1530, 0, 0); nnr += int'(!snap.instr_ready);
    cycle(1, 'h2350, 0, 0); nnr += int'(!snap.instr_ready);
    for (int k = 0; k < 4; k++) begin
      cycle(k == 0, 'h3670, 0, 0);
      nnr += int'(!snap.instr_ready);
    end
    check("hazard_bubbles", nnr, HAZ ? 1 : 0);
    idle(3);

    // Asynchronous reset while in MEM_WAIT
    cycle(1, 'h1008, 0, 0); cycle(0, 0, 0, 1);
    idle(3);
    check("pre_reset_mem_req", int'(mem_req), 1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_mem_req", int'(mem_req), 0);
    check("async_reset_aluf", int'(aluf), 0);
    check("async_reset_ready", int'(instr_ready), 0);
    do_reset();

    // Randomized traffic with periodic ack blackouts to force timeouts
    blackout = 0;
    for (int i = 0; i < 1500; i++) begin
      int w;
      bit ack;
      if (i % 300 == 100) blackout = 20;
      ack = (blackout > 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
      if (blackout > 0) blackout--;
      w = ($urandom_range(0, 15) << 12) | ($urandom_range(0, 5) << 8) |
          ($urandom_range(0, 5) << 4) | ($urandom_range(0, 1) << 3) |
          $urandom_range(0, 7);
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 15), ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
